// File: rtl/sort_pkg.sv
// sort_pkg: shared types for the sorted stream collector and its order checker.
// Beat fields are held at a fixed maximum width so one struct serves every parameterisation.
package sort_pkg;
   localparam int SORT_KW_MAX = 32;
   localparam int SORT_IW_MAX = 16;
   typedef enum logic {S_COLLECT, S_DONE} state_t;
   typedef struct packed {
      logic [SORT_KW_MAX-1:0] key;
      logic [SORT_IW_MAX-1:0] index;
   } sort_beat_t;
   typedef struct packed {
      logic order;
      logic stability;
      logic index;
   } sort_err_t;
endpackage

// File: rtl/sort_order_checker.sv
// sort_order_checker: combinational check of the current beat against the previous beat
// and the bitmap of indices already seen in this frame.
module sort_order_checker
   import sort_pkg::*;
#(
   parameter int N = 24
) (
   input  logic       first_i,
   input  logic [N-1:0] seen_i,
   input  sort_beat_t cur_i,
   input  sort_beat_t prev_i,
   output sort_err_t  err_o
);
   logic dup;
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < N; i++) dup = dup | (seen_i[i] && cur_i.index == SORT_IW_MAX'(i));
      err_o.order     = !first_i && cur_i.key < prev_i.key;
      err_o.stability = !first_i && cur_i.key == prev_i.key && cur_i.index <= prev_i.index;
      err_o.index     = cur_i.index >= SORT_IW_MAX'(N) || dup;
   end
endmodule

// File: rtl/sorted_stream_collector.sv
// sorted_stream_collector: reassembles one sorted (key, index) frame into parallel vectors
// and flags ordering, stability and index faults. SORT_COLLECTOR_RANKS_EN builds out_ranks.
module sorted_stream_collector
   import sort_pkg::*;
#(
   parameter int NUMBER_OF_ELEMENTS = 24,
   parameter int KEY_WIDTH          = 8,
   parameter int OUTPUT_INDEX_WIDTH = 5
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [KEY_WIDTH-1:0]                           axis_in_key,
   input  logic [OUTPUT_INDEX_WIDTH-1:0]                  axis_in_index,
   input  logic                                           axis_in_valid,
   output logic                                           axis_in_ready,
   output logic [NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0]        out_keys,
   output logic [NUMBER_OF_ELEMENTS*OUTPUT_INDEX_WIDTH-1:0] out_indices,
   output logic [NUMBER_OF_ELEMENTS*OUTPUT_INDEX_WIDTH-1:0] out_ranks,
   output logic                                           out_valid,
   input  logic                                           out_ack,
   output logic                                           order_error,
   output logic                                           stability_error,
   output logic                                           index_error
);
   localparam int N  = NUMBER_OF_ELEMENTS;
   localparam int KW = KEY_WIDTH;
   localparam int IW = OUTPUT_INDEX_WIDTH;
   localparam logic [IW:0] LAST = (IW+1)'(N-1);
   state_t                  state_q, state_d;
   logic [IW:0]             count_q, count_d;
   logic [N-1:0]            seen_q, seen_d, hit;
   sort_err_t               err_q, err_d, chk;
   sort_beat_t              cur, prev_q;
   logic [N-1:0][KW-1:0]    keys_q;
   logic [N-1:0][IW-1:0]    idx_q;
   logic                    accept;
   assign axis_in_ready   = rst && state_q == S_COLLECT;
   assign accept          = axis_in_valid && axis_in_ready;
   assign cur             = '{key: SORT_KW_MAX'(axis_in_key), index: SORT_IW_MAX'(axis_in_index)};
   assign out_valid       = state_q == S_DONE;
   assign out_keys        = keys_q;
   assign out_indices     = idx_q;
   assign order_error     = err_q.order;
   assign stability_error = err_q.stability;
   assign index_error     = err_q.index;
   sort_order_checker #(.N(N)) u_chk (
      .first_i (count_q == '0),
      .seen_i  (seen_q),
      .cur_i   (cur),
      .prev_i  (prev_q),
      .err_o   (chk)
   );
   // Out-of-range indices decode to no bit, so they never touch seen or the rank array.
   always_comb begin
      hit = '0;
      for (int i = 0; i < N; i++) hit[i] = axis_in_index == IW'(i);
   end
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      seen_d  = seen_q;
      err_d   = err_q;
      if (state_q == S_COLLECT) begin
         if (accept) begin
            count_d = count_q + (IW+1)'(1);
            seen_d  = seen_q | hit;
            err_d   = err_q | chk;
            state_d = count_q == LAST ? S_DONE : S_COLLECT;
         end
      end else if (out_ack) begin
         state_d = S_COLLECT;
         count_d = '0;
         seen_d  = '0;
         err_d   = '0;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_COLLECT;
         count_q <= '0;
         seen_q  <= '0;
         err_q   <= '0;
         prev_q  <= '0;
         keys_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         seen_q  <= seen_d;
         err_q   <= err_d;
         if (accept) begin
            prev_q <= cur;
            for (int i = 0; i < N; i++) begin
               if (count_q == (IW+1)'(i)) begin
                  keys_q[i] <= axis_in_key;
                  idx_q[i]  <= axis_in_index;
               end
            end
         end
      end
   end
`ifdef SORT_COLLECTOR_RANKS_EN
   logic [N-1:0][IW-1:0] ranks_q;
   always_ff @(posedge clk) begin
      if (!rst) ranks_q <= '0;
      else if (accept) begin
         for (int j = 0; j < N; j++) if (hit[j]) ranks_q[j] <= count_q[IW-1:0];
      end
   end
   assign out_ranks = ranks_q;
`else
   assign out_ranks = '0;
`endif
endmodule
